// File: rtl/qrcode_pkg.sv
// Shared definitions for the QR finder-pattern detector register port: address map,
// result word layout and the bus sequencer state encoding.
package qrcode_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StArm,
      StClrRd,
      StClrChk,
      StSetRd,
      StSetChk,
      StGap,
      StDrnRd,
      StDrnChk,
      StOut,
      StDone
   } qr_state_e;

   localparam logic [10:0] cQR_CTRL_ADDR   = 11'h000;
   localparam logic [10:0] cQR_RESULT_BASE = 11'h400;
   localparam logic [31:0] cQR_TERMINATOR  = 32'hFFFF_FFFF;

   localparam int unsigned cQR_UPDATE_BIT = 0;
   localparam int unsigned cQR_FIELD_W    = 10;
   localparam int unsigned cQR_LINE_LSB   = 20;
   localparam int unsigned cQR_HST_LSB    = 10;
   localparam int unsigned cQR_HED_LSB    = 0;

   function automatic logic [10:0] qr_result_addr(input logic [9:0] idx);
      return cQR_RESULT_BASE | {1'b0, idx};
   endfunction

endpackage

// File: rtl/qrcode_frame_sequencer.sv
// Bus-side controller for the QR detector: arms a frame, polls UPDATE, drains the result RAM
// up to the terminator and streams each centre-run entry with a ready/valid handshake.
module qrcode_frame_sequencer
   import qrcode_pkg::*;
#(
   parameter int unsigned pMAX_ENTRIES = 1023,
   parameter int unsigned pPOLL_GAP    = 15,
   parameter logic [23:0] pTIMEOUT     = 24'd8_000_000
) (
   input  logic        iCLK,
   input  logic        iRESET,
   input  logic        iSTART,
   input  logic        iCONTINUOUS,
   input  logic [1:0]  iOUTMODE,
   output logic        oBUSY,
   output logic [10:0] oADDRESS,
   output logic [31:0] oWRITE_DATA,
   output logic        oWRITE,
   output logic        oREAD,
   input  logic [31:0] iREAD_DATA,
   output logic        oENT_VALID,
   input  logic        iENT_READY,
   output logic [9:0]  oENT_LINE,
   output logic [9:0]  oENT_HST,
   output logic [9:0]  oENT_HED,
   output logic        oFRAME_DONE,
   output logic [9:0]  oENT_COUNT,
   output logic        oTIMEOUT
);

   localparam logic [9:0]  cMaxIdx  = 10'(pMAX_ENTRIES);
   localparam logic [15:0] cGapLast = 16'(pPOLL_GAP - 1);

   qr_state_e   state_q, state_d;
   logic [9:0]  idx_q, idx_d;
   logic [15:0] gap_q, gap_d;
   logic [23:0] tmo_q, tmo_d;
   logic        poll_set_q, poll_set_d;
   logic [10:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        write_q, write_d, read_q, read_d;
   logic        busy_q, busy_d, valid_q, valid_d;
   logic        done_q, done_d, tmo_pulse_q, tmo_pulse_d;
   logic [9:0]  line_q, line_d, hst_q, hst_d, hed_q, hed_d, count_q, count_d;
   logic        polling, timed_out;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      gap_d       = gap_q;
      tmo_d       = tmo_q;
      poll_set_d  = poll_set_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      line_d      = line_q;
      hst_d       = hst_q;
      hed_d       = hed_q;
      count_d     = count_q;

      // The abort timer only covers the arm-to-complete wait, never the drain.
      polling   = state_q inside {StClrRd, StClrChk, StSetRd, StSetChk, StGap};
      timed_out = polling && ((tmo_q + 24'd1) >= pTIMEOUT);
      if (polling) begin
         tmo_d = tmo_q + 24'd1;
      end

      case (state_q)
         StIdle: begin
            if (iSTART) state_d = StArm;
         end
         StArm: begin
            tmo_d   = '0;
            state_d = StClrRd;
         end
         StClrRd:  state_d = StClrChk;
         StClrChk: begin
            if (!iREAD_DATA[cQR_UPDATE_BIT]) begin
               state_d = StSetRd;
            end else begin
               poll_set_d = 1'b0;
               state_d    = StGap;
            end
         end
         StSetRd:  state_d = StSetChk;
         StSetChk: begin
            if (iREAD_DATA[cQR_UPDATE_BIT]) begin
               idx_d   = '0;
               state_d = StDrnRd;
            end else begin
               poll_set_d = 1'b1;
               state_d    = StGap;
            end
         end
         StGap: begin
            if (gap_q == cGapLast) begin
               gap_d   = '0;
               state_d = poll_set_q ? StSetRd : StClrRd;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         StDrnRd:  state_d = StDrnChk;
         StDrnChk: begin
            if (iREAD_DATA == cQR_TERMINATOR || idx_q == cMaxIdx) begin
               count_d = idx_q;
               state_d = StDone;
            end else begin
               line_d  = iREAD_DATA[cQR_LINE_LSB +: cQR_FIELD_W];
               hst_d   = iREAD_DATA[cQR_HST_LSB +: cQR_FIELD_W];
               hed_d   = iREAD_DATA[cQR_HED_LSB +: cQR_FIELD_W];
               state_d = StOut;
            end
         end
         StOut: begin
            if (iENT_READY) begin
               idx_d   = idx_q + 10'd1;
               state_d = StDrnRd;
            end
         end
         StDone:  state_d = iCONTINUOUS ? StArm : StIdle;
         default: state_d = StIdle;
      endcase

      if (timed_out) begin
         state_d = StIdle;
         tmo_d   = '0;
         gap_d   = '0;
      end

      // Outputs are decoded from the state being entered, so they are registered yet
      // line up with the state they belong to.
      read_d      = state_d inside {StClrRd, StSetRd, StDrnRd};
      write_d     = (state_d == StArm) || timed_out;
      busy_d      = state_d != StIdle;
      valid_d     = state_d == StOut;
      done_d      = state_d == StDone;
      tmo_pulse_d = timed_out;

      if (timed_out) begin
         addr_d  = cQR_CTRL_ADDR;
         wdata_d = {29'b0, iOUTMODE, 1'b0};
      end else if (state_d == StArm) begin
         addr_d  = cQR_CTRL_ADDR;
         wdata_d = {29'b0, iOUTMODE, 1'b1};
      end else if (state_d == StClrRd || state_d == StSetRd) begin
         addr_d = cQR_CTRL_ADDR;
      end else if (state_d == StDrnRd) begin
         addr_d = qr_result_addr(idx_d);
      end
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         gap_q       <= '0;
         tmo_q       <= '0;
         poll_set_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         tmo_pulse_q <= 1'b0;
         line_q      <= '0;
         hst_q       <= '0;
         hed_q       <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         tmo_q       <= tmo_d;
         poll_set_q  <= poll_set_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         read_q      <= read_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         tmo_pulse_q <= tmo_pulse_d;
         line_q      <= line_d;
         hst_q       <= hst_d;
         hed_q       <= hed_d;
         count_q     <= count_d;
      end
   end

   assign oBUSY       = busy_q;
   assign oADDRESS    = addr_q;
   assign oWRITE_DATA = wdata_q;
   assign oWRITE      = write_q;
   assign oREAD       = read_q;
   assign oENT_VALID  = valid_q;
   assign oENT_LINE   = line_q;
   assign oENT_HST    = hst_q;
   assign oENT_HED    = hed_q;
   assign oFRAME_DONE = done_q;
   assign oENT_COUNT  = count_q;
   assign oTIMEOUT    = tmo_pulse_q;

endmodule

// File: tb/tb_qrcode_frame_sequencer.sv
// Directed bench for qrcode_frame_sequencer: behavioural detector port model, a bus/stream
// monitor, and hand-computed expectations for each scenario.
module tb_qrcode_frame_sequencer;

   logic        iCLK = 1'b0;
   logic        iRESET = 1'b1;
   logic        iSTART = 1'b0;
   logic        iCONTINUOUS = 1'b0;
   logic [1:0]  iOUTMODE = 2'b00;
   logic        iENT_READY = 1'b0;
   logic [31:0] iREAD_DATA;
   logic        oBUSY, oWRITE, oREAD, oENT_VALID, oFRAME_DONE, oTIMEOUT;
   logic [10:0] oADDRESS;
   logic [31:0] oWRITE_DATA;
   logic [9:0]  oENT_LINE, oENT_HST, oENT_HED, oENT_COUNT;

   qrcode_frame_sequencer #(
      .pMAX_ENTRIES (4),
      .pPOLL_GAP    (4),
      .pTIMEOUT     (24'd100)
   ) u_dut (
      .iCLK        (iCLK),
      .iRESET      (iRESET),
      .iSTART      (iSTART),
      .iCONTINUOUS (iCONTINUOUS),
      .iOUTMODE    (iOUTMODE),
      .oBUSY       (oBUSY),
      .oADDRESS    (oADDRESS),
      .oWRITE_DATA (oWRITE_DATA),
      .oWRITE      (oWRITE),
      .oREAD       (oREAD),
      .iREAD_DATA  (iREAD_DATA),
      .oENT_VALID  (oENT_VALID),
      .iENT_READY  (iENT_READY),
      .oENT_LINE   (oENT_LINE),
      .oENT_HST    (oENT_HST),
      .oENT_HED    (oENT_HED),
      .oFRAME_DONE (oFRAME_DONE),
      .oENT_COUNT  (oENT_COUNT),
      .oTIMEOUT    (oTIMEOUT)
   );

   initial forever #5 iCLK = ~iCLK;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   initial forever begin
      @(posedge iCLK);
      cyc++;
   end

   // Detector model: UPDATE stays 1 for clr_n polls after an arm, then 0 for set_n polls.
   logic [31:0] mem [0:1023];
   logic [29:0] tbl [0:9];
   int clr_n = 0, set_n = 0;
   int ph = 0, pn = 0;
   initial forever begin
      @(posedge iCLK);
      if (oWRITE && oADDRESS == 11'h000 && oWRITE_DATA[0]) begin
         ph = 0;
         pn = 0;
      end
      if (oREAD) begin
         if (oADDRESS[10]) iREAD_DATA <= mem[oADDRESS[9:0]];
         else if (ph == 0) begin
            if (pn < clr_n) begin
               iREAD_DATA <= 32'h1;
               pn++;
            end else begin
               iREAD_DATA <= 32'h0;
               ph = 1;
               pn = 0;
            end
         end else if (pn < set_n) begin
            iREAD_DATA <= 32'h0;
            pn++;
         end else iREAD_DATA <= 32'h1;
      end else iREAD_DATA <= 32'hA5A5_5A5A;
   end

   // Monitor, sampled mid-cycle.
   logic        clr_stats = 1'b0;
   int          n_wr, n_rd, n_res_rd, n_both, n_long, n_clr_wr, n_done, n_tmo, n_valid_cyc;
   int          stable_err, last_arm_cyc, st_cyc;
   logic [31:0] last_arm_data;
   logic [10:0] max_res_addr;
   logic [29:0] acc_q[$];
   int          acc_cyc[$];
   logic        pv, pr, prd, pwr;
   logic [29:0] pf;
   initial forever begin
      @(negedge iCLK);
      if (clr_stats) begin
         n_wr = 0; n_rd = 0; n_res_rd = 0; n_both = 0; n_long = 0; n_clr_wr = 0;
         n_done = 0; n_tmo = 0; n_valid_cyc = 0; stable_err = 0; max_res_addr = '0;
         acc_q.delete();
         acc_cyc.delete();
         pv = 0; pr = 0; prd = 0; pwr = 0; pf = '0;
      end else begin
         if (oWRITE && oREAD) n_both++;
         if ((oREAD && prd) || (oWRITE && pwr)) n_long++;
         if (oWRITE) begin
            n_wr++;
            if (oADDRESS == 11'h000 && oWRITE_DATA[0]) begin
               last_arm_cyc  = cyc;
               last_arm_data = oWRITE_DATA;
            end
            if (oADDRESS == 11'h000 && !oWRITE_DATA[0]) n_clr_wr++;
         end
         if (oREAD) begin
            n_rd++;
            if (oADDRESS[10]) begin
               n_res_rd++;
               if (oADDRESS > max_res_addr) max_res_addr = oADDRESS;
            end
         end
         if (oENT_VALID) begin
            n_valid_cyc++;
            if (iENT_READY) begin
               acc_q.push_back({oENT_LINE, oENT_HST, oENT_HED});
               acc_cyc.push_back(cyc);
            end
         end
         if (pv && !pr && (!oENT_VALID || {oENT_LINE, oENT_HST, oENT_HED} != pf)) stable_err++;
         if (oFRAME_DONE) n_done++;
         if (oTIMEOUT) n_tmo++;
         pv  = oENT_VALID;
         pr  = iENT_READY;
         pf  = {oENT_LINE, oENT_HST, oENT_HED};
         prd = oREAD;
         pwr = oWRITE;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic clear();
      clr_stats = 1'b1;
      @(negedge iCLK);
      #1 clr_stats = 1'b0;
   endtask

   task automatic pulse_start();
      iSTART = 1'b1;
      st_cyc = cyc;
      tick();
      iSTART = 1'b0;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return oFRAME_DONE;
         1:       return oTIMEOUT;
         default: return oENT_VALID;
      endcase
   endfunction

   task automatic wait_sig(input string tag, input int sel, input int limit);
      int i = 0;
      while (!sig(sel) && i < limit) begin
         tick();
         i++;
      end
      check(tag, 32'(sig(sel)), 32'd1);
   endtask

   task automatic load_frame(input int n);
      for (int i = 0; i < n; i++) mem[i] = {2'b10, tbl[i]};
      mem[n] = 32'hFFFF_FFFF;
   endtask

   task automatic check_entries(input string tag, input int n);
      check({tag, "_n"}, 32'(acc_q.size()), 32'(n));
      for (int i = 0; i < n && i < acc_q.size(); i++)
         check($sformatf("%s_e%0d", tag, i), 32'(acc_q[i]), 32'(tbl[i]));
   endtask

   int rd0, rd1, d;

   initial begin
      tbl[0] = {10'd5, 10'd100, 10'd120};
      tbl[1] = {10'd17, 10'd300, 10'd333};
      tbl[2] = {10'd1023, 10'd0, 10'd1022};
      tbl[3] = {10'd400, 10'd512, 10'd640};
      for (int i = 4; i < 10; i++) tbl[i] = {10'(i), 10'(i * 2), 10'(i * 3)};

      // Reset state
      tick();
      tick();
      check("rst_ctrl", 32'({oBUSY, oWRITE, oREAD, oENT_VALID, oFRAME_DONE, oTIMEOUT}), 32'd0);
      check("rst_bus", 32'(oADDRESS) | oWRITE_DATA, 32'd0);
      check("rst_ent", 32'({oENT_LINE, oENT_HST, oENT_HED}) | 32'(oENT_COUNT), 32'd0);
      iRESET = 1'b0;
      clear();

      // Nominal: 2 busy polls, 5 pending polls, 3 entries
      load_frame(3);
      clr_n = 2;
      set_n = 5;
      iOUTMODE = 2'b10;
      iENT_READY = 1'b1;
      tick();
      pulse_start();
      wait_sig("nom_done", 0, 400);
      check("nom_latency", 32'(last_arm_cyc - st_cyc), 32'd1);
      check("nom_arm_data", last_arm_data, 32'h5);
      check("nom_count", 32'(oENT_COUNT), 32'd3);
      check("nom_busy_at_done", 32'(oBUSY), 32'd1);
      tick();
      check("nom_busy_after", 32'(oBUSY), 32'd0);
      check_entries("nom", 3);
      check("nom_ctrl_reads", 32'(n_rd - n_res_rd), 32'd9);
      check("nom_res_reads", 32'(n_res_rd), 32'd4);
      check("nom_valid_cycles", 32'(n_valid_cyc), 32'd3);
      if (acc_cyc.size() == 3) check("nom_throughput", 32'(acc_cyc[2] - acc_cyc[0]), 32'd6);
      check("nom_bus_rules", 32'(n_both + n_long), 32'd0);

      // Backpressure on entry 1, with a stray iSTART while busy
      clear();
      load_frame(3);
      iENT_READY = 1'b0;
      iOUTMODE = 2'b01;
      tick();
      pulse_start();
      rd0 = 0;
      rd1 = 0;
      for (int e = 0; e < 3; e++) begin
         wait_sig($sformatf("bp_valid%0d", e), 2, 400);
         if (e == 1) begin
            rd0 = n_rd;
            repeat (3) tick();
            pulse_start();
            repeat (3) tick();
            rd1 = n_rd;
         end
         iENT_READY = 1'b1;
         tick();
         iENT_READY = 1'b0;
      end
      wait_sig("bp_done", 0, 100);
      check("bp_count", 32'(oENT_COUNT), 32'd3);
      check("bp_stall_reads", 32'(rd1 - rd0), 32'd0);
      check("bp_stable", 32'(stable_err), 32'd0);
      check("bp_valid_cycles", 32'(n_valid_cyc), 32'd10);
      check("bp_writes", 32'(n_wr), 32'd1);
      check("bp_arm_data", last_arm_data, 32'h3);
      check_entries("bp", 3);

      // Empty frame
      tick();
      clear();
      load_frame(0);
      iENT_READY = 1'b1;
      tick();
      pulse_start();
      wait_sig("empty_done", 0, 200);
      check("empty_count", 32'(oENT_COUNT), 32'd0);
      check("empty_valid", 32'(n_valid_cyc), 32'd0);
      check("empty_res_reads", 32'(n_res_rd), 32'd1);

      // Overflow: 10 valid words, limit 4
      tick();
      clear();
      load_frame(10);
      tick();
      pulse_start();
      wait_sig("ovf_done", 0, 200);
      check("ovf_count", 32'(oENT_COUNT), 32'd4);
      check("ovf_res_reads", 32'(n_res_rd), 32'd5);
      check("ovf_max_addr", 32'(max_res_addr), 32'h404);
      check_entries("ovf", 4);

      // Timeout: UPDATE never sets
      tick();
      clear();
      clr_n = 0;
      set_n = 1_000_000;
      tick();
      pulse_start();
      wait_sig("tmo_pulse", 1, 300);
      d = cyc - last_arm_cyc;
      if (d < 94 || d > 106) $display("FAIL tmo_window: got %0d cycles, expected 94..106", d);
      check("tmo_window", 32'(d >= 94 && d <= 106), 32'd1);
      check("tmo_write", 32'({oWRITE, oADDRESS, oWRITE_DATA[0]}), 32'({1'b1, 11'h000, 1'b0}));
      check("tmo_busy", 32'(oBUSY), 32'd0);
      rd0 = n_rd;
      repeat (20) tick();
      check("tmo_quiet", 32'(n_rd - rd0), 32'd0);
      check("tmo_pulses", 32'(n_tmo), 32'd1);
      check("tmo_no_done", 32'(n_done), 32'd0);
      check("tmo_clr_writes", 32'(n_clr_wr), 32'd1);
      check("tmo_writes", 32'(n_wr), 32'd2);

      // Continuous mode, then async reset mid-drain of frame 3
      clear();
      load_frame(2);
      clr_n = 0;
      set_n = 0;
      iCONTINUOUS = 1'b1;
      iENT_READY = 1'b1;
      tick();
      pulse_start();
      wait_sig("cont_done1", 0, 200);
      tick();
      check("cont_rearm", 32'({oWRITE, oADDRESS, oWRITE_DATA[0], oBUSY}), 32'({1'b1, 11'h0, 2'b11}));
      wait_sig("cont_done2", 0, 200);
      wait_sig("cont_valid3", 2, 200);
      check("cont_entries", 32'(acc_q.size()), 32'd4);
      iRESET = 1'b1;
      #1;
      check("rst_mid_ctrl", 32'({oBUSY, oWRITE, oREAD, oENT_VALID, oFRAME_DONE, oTIMEOUT}), 32'd0);
      check("rst_mid_ent", 32'({oENT_LINE, oENT_HST, oENT_HED}) | 32'(oENT_COUNT), 32'd0);
      check("rst_mid_bus", 32'(oADDRESS) | oWRITE_DATA, 32'd0);
      tick();
      tick();
      iRESET = 1'b0;
      clear();
      repeat (20) tick();
      check("rst_no_strobes", 32'(n_rd + n_wr), 32'd0);

      // Recovery; iCONTINUOUS dropped mid-frame stops after this frame
      pulse_start();
      iCONTINUOUS = 1'b0;
      wait_sig("rec_done", 0, 200);
      check("rec_count", 32'(oENT_COUNT), 32'd2);
      repeat (10) tick();
      check("rec_writes", 32'(n_wr), 32'd1);
      check("rec_idle", 32'(oBUSY), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
